program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 24 ++
 rtl/loader_csum.sv | 22 ++
 rtl/program_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
// CK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int INSTR_W   = 11;
  localparam int ADDR_W    = 3;
  localparam int WORDS_DEF = 8;

  localparam logic [7:0] HDR_MASK = 8'hF8;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WR,
    RUN,
    ERR
`ifdef LOADER_CHECKSUM_EN
    ,
    CK
`endif
  } state_e;

endpackage

// File: rtl/loader_csum.sv
// XOR accumulator over the accepted payload bytes.
// Used only when LOADER_CHECKSUM_EN is defined.
module loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_q ^ data_i;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: two bytes per word into program RAM.
// Optional trailing XOR checksum under LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int WORDS   = loader_pkg::WORDS_DEF,
  parameter int INSTR_W = loader_pkg::INSTR_W,
  parameter int ADDR_W  = loader_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [INSTR_W-1:0] ram_wdata,
  output logic               pc_enable,
  output logic               busy,
  output logic               err
);

  import loader_pkg::*;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [2:0]         hi_q, hi_d;
  logic               rdy_q, rdy_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               pce_q, pce_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic xfer;
  logic last;

  assign xfer = in_valid & rdy_q;
  assign last = (cnt_q == ADDR_W'(WORDS - 1));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
  logic       acc_en;

  assign acc_en = xfer & ~start &
                  ((state_q == HI) | (state_q == LO));

  loader_csum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start),
    .en_i   (acc_en),
    .data_i (in_data),
    .acc_o  (acc)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
    end
  end

  // start wins over any byte offered in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    if (start) begin
      state_d = HI;
      cnt_d   = '0;
      hi_d    = '0;
    end else begin
      unique case (state_q)
        HI: begin
          if (xfer) begin
            if ((in_data & HDR_MASK) != 8'h00) begin
              state_d = ERR;
            end else begin
              hi_d    = in_data[2:0];
              state_d = LO;
            end
          end
        end
        LO: begin
          if (xfer) state_d = WR;
        end
        WR: begin
          if (last) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CK;
`else
            state_d = RUN;
`endif
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CK: begin
          if (xfer) state_d = (in_data == acc) ? RUN : ERR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // outputs are decoded from the next state and registered
  always_comb begin
    rdy_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    pce_d   = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_d)
      HI, LO: begin
        rdy_d  = 1'b1;
        busy_d = 1'b1;
      end
      WR: begin
        we_d    = 1'b1;
        busy_d  = 1'b1;
        addr_d  = cnt_q;
        wdata_d = INSTR_W'({hi_q, in_data});
      end
`ifdef LOADER_CHECKSUM_EN
      CK: begin
        rdy_d  = 1'b1;
        busy_d = 1'b1;
      end
`endif
      RUN:     pce_d = 1'b1;
      ERR:     err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pce_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pce_q   <= pce_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = rdy_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign pc_enable = pce_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
